// File: rtl/text_cursor_feeder.sv
// Byte-stream to glyph-write converter with a tracked (row,col) cursor, newline, clear and a
// scroll handshake. Optional backspace support is enabled by defining TEXT_FEEDER_BACKSPACE_EN.
module text_cursor_feeder #(
    parameter  int ROWS      = 7,
    parameter  int COLS      = 20,
    parameter  int UNK_GLYPH = 130,
    localparam int ROW_W     = $clog2(ROWS),
    localparam int COL_W     = $clog2(COLS),
    localparam int ID_W      = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [7:0]       char_in,
    input  logic             char_valid,
    output logic             char_ready,
    output logic [ID_W-1:0]  glyph_id,
    output logic [ROW_W-1:0] glyph_row,
    output logic [COL_W-1:0] glyph_col,
    output logic             glyph_we,
    output logic             scroll_req,
    input  logic             scroll_ack,
    output logic             clear_req,
    output logic [ROW_W-1:0] cur_row,
    output logic [COL_W-1:0] cur_col
);

    typedef enum logic {IDLE, SCROLL} state_t;

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ID_W-1:0]  glyph_id_q, glyph_id_d;
    logic [ROW_W-1:0] glyph_row_q, glyph_row_d;
    logic [COL_W-1:0] glyph_col_q, glyph_col_d;
    logic             glyph_we_q, glyph_we_d;
    logic             clear_req_q, clear_req_d;
    logic             accept;

    function automatic logic [ID_W-1:0] map_code(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return ID_W'(c - 8'h30);
        if (c >= 8'h41 && c <= 8'h5A) return ID_W'(c - 8'h37);
        if (c >= 8'h61 && c <= 8'h7A) return ID_W'(c - 8'h3D);
        if (c >= 8'h80 && c <= 8'hC3) return ID_W'(c - 8'h42);
        return ID_W'(UNK_GLYPH);
    endfunction

    assign accept = char_valid && (state_q == IDLE);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        glyph_id_d  = glyph_id_q;
        glyph_row_d = glyph_row_q;
        glyph_col_d = glyph_col_q;
        glyph_we_d  = 1'b0;
        clear_req_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (char_in == 8'hFF) begin
                        row_d       = '0;
                        col_d       = '0;
                        clear_req_d = 1'b1;
                    end else if (char_in == 8'h0A) begin
                        col_d = '0;
                        if (row_q == LAST_ROW) state_d = SCROLL;
                        else                   row_d   = row_q + 1'b1;
`ifdef TEXT_FEEDER_BACKSPACE_EN
                    end else if (char_in == 8'h08) begin
                        if (col_q != '0) begin
                            col_d = col_q - 1'b1;
                        end else if (row_q != '0) begin
                            row_d = row_q - 1'b1;
                            col_d = LAST_COL;
                        end
                        // Blank the cell the cursor lands on (same cell when already at home).
                        glyph_we_d  = 1'b1;
                        glyph_id_d  = 8'd255;
                        glyph_row_d = row_d;
                        glyph_col_d = col_d;
`endif
                    end else begin
                        glyph_we_d  = 1'b1;
                        glyph_id_d  = map_code(char_in);
                        glyph_row_d = row_q;
                        glyph_col_d = col_q;
                        if (col_q != LAST_COL) begin
                            col_d = col_q + 1'b1;
                        end else begin
                            col_d = '0;
                            if (row_q == LAST_ROW) state_d = SCROLL;
                            else                   row_d   = row_q + 1'b1;
                        end
                    end
                end
            end
            SCROLL: begin
                if (scroll_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            row_q       <= '0;
            col_q       <= '0;
            glyph_id_q  <= '0;
            glyph_row_q <= '0;
            glyph_col_q <= '0;
            glyph_we_q  <= 1'b0;
            clear_req_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            glyph_id_q  <= glyph_id_d;
            glyph_row_q <= glyph_row_d;
            glyph_col_q <= glyph_col_d;
            glyph_we_q  <= glyph_we_d;
            clear_req_q <= clear_req_d;
        end
    end

    // Scroll request is decoded from the state register so an async reset drops it at once.
    assign char_ready = (state_q == IDLE);
    assign scroll_req = (state_q == SCROLL);
    assign glyph_id   = glyph_id_q;
    assign glyph_row  = glyph_row_q;
    assign glyph_col  = glyph_col_q;
    assign glyph_we   = glyph_we_q;
    assign clear_req  = clear_req_q;
    assign cur_row    = row_q;
    assign cur_col    = col_q;

endmodule

// File: tb/tb_text_cursor_feeder.sv
// Self-checking bench for text_cursor_feeder: cursor model plus a queue of expected glyph writes.
module tb_text_cursor_feeder;

    localparam int ROWS = 7;
    localparam int COLS = 20;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] char_in;
    logic       char_valid;
    logic       char_ready;
    logic [7:0] glyph_id;
    logic [2:0] glyph_row;
    logic [4:0] glyph_col;
    logic       glyph_we;
    logic       scroll_req;
    logic       scroll_ack;
    logic       clear_req;
    logic [2:0] cur_row;
    logic [4:0] cur_col;

    text_cursor_feeder #(.ROWS(ROWS), .COLS(COLS), .UNK_GLYPH(130)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .char_in    (char_in),
        .char_valid (char_valid),
        .char_ready (char_ready),
        .glyph_id   (glyph_id),
        .glyph_row  (glyph_row),
        .glyph_col  (glyph_col),
        .glyph_we   (glyph_we),
        .scroll_req (scroll_req),
        .scroll_ack (scroll_ack),
        .clear_req  (clear_req),
        .cur_row    (cur_row),
        .cur_col    (cur_col)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [7:0] id;
        logic [2:0] row;
        logic [4:0] col;
    } wr_t;

    wr_t exp_q[$];
    int  errors = 0;
    int  checks = 0;
    int  clear_cnt = 0;
    int  exp_row = 0;
    int  exp_col = 0;
    bit  exp_scroll = 0;

    function automatic logic [7:0] ref_glyph(input logic [7:0] c);
        int v;
        v = int'(c);
        if (v >= 48  && v <= 57)  return 8'(v - 48);
        if (v >= 65  && v <= 90)  return 8'(v - 65 + 10);
        if (v >= 97  && v <= 122) return 8'(v - 97 + 36);
        if (v >= 128 && v <= 195) return 8'(v - 128 + 62);
        return 8'd130;
    endfunction

    task automatic model_advance();
        if (exp_col < COLS - 1) begin
            exp_col++;
        end else begin
            exp_col = 0;
            if (exp_row == ROWS - 1) exp_scroll = 1;
            else                     exp_row++;
        end
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'hFF) begin
            exp_row = 0;
            exp_col = 0;
            exp_scroll = 0;
        end else if (b == 8'h0A) begin
            exp_col = 0;
            if (exp_row == ROWS - 1) exp_scroll = 1;
            else                     exp_row++;
`ifdef TEXT_FEEDER_BACKSPACE_EN
        end else if (b == 8'h08) begin
            if (exp_col > 0) begin
                exp_col--;
            end else if (exp_row > 0) begin
                exp_row--;
                exp_col = COLS - 1;
            end
            exp_q.push_back({8'd255, 3'(exp_row), 5'(exp_col)});
`endif
        end else begin
            exp_q.push_back({ref_glyph(b), 3'(exp_row), 5'(exp_col)});
            model_advance();
        end
    endtask

    // Drives one byte, waits (bounded) for char_ready, and records the expectation on accept.
    task automatic send(input logic [7:0] b);
        int waited;
        waited = 0;
        @(negedge clock);
        char_in    = b;
        char_valid = 1'b1;
        while (char_ready !== 1'b1 && waited < 50) begin
            @(negedge clock);
            waited++;
        end
        if (char_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: char_ready=%b required 1 for byte %h", char_ready, b);
            char_valid = 1'b0;
        end else begin
            model_byte(b);
            @(posedge clock);
            #1;
            char_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        scroll_ack = 1'b0;
        exp_q.delete();
        exp_row    = 0;
        exp_col    = 0;
        exp_scroll = 0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
    endtask

    // Glyph-write monitor: every strobe must match the oldest expected write.
    always @(negedge clock) begin
        if (reset_n === 1'b1 && glyph_we === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got id=%0d r=%0d c=%0d required no write",
                         glyph_id, glyph_row, glyph_col);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                if ({glyph_id, glyph_row, glyph_col} !== w) begin
                    errors++;
                    $display("FAIL glyph_write: got id=%0d r=%0d c=%0d required id=%0d r=%0d c=%0d",
                             glyph_id, glyph_row, glyph_col, w.id, w.row, w.col);
                end
            end
        end
        if (reset_n === 1'b1 && clear_req === 1'b1) clear_cnt++;
    end

    task automatic test_reset();
        reset_n    = 1'b0;
        char_valid = 1'b0;
        char_in    = 8'h00;
        scroll_ack = 1'b0;
        @(negedge clock);
        checks++;
        if ({char_ready, glyph_we, scroll_req, clear_req, glyph_id, glyph_row, glyph_col, cur_row, cur_col}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 3'd0, 5'd0, 3'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset_state: ready=%b we=%b scr=%b clr=%b id=%0d gr=%0d gc=%0d row=%0d col=%0d required ready=1 rest 0",
                     char_ready, glyph_we, scroll_req, clear_req, glyph_id, glyph_row, glyph_col, cur_row, cur_col);
        end
        do_reset();
    endtask

    task automatic test_back_to_back();
        do_reset();
        send("A");
        send("z");
        send("5");
        @(negedge clock);
        #1;
        checks++;
        if ({cur_row, cur_col} !== {3'd0, 5'd3} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL back_to_back: row=%0d col=%0d pending=%0d required row=0 col=3 pending=0",
                     cur_row, cur_col, exp_q.size());
        end
    endtask

    task automatic test_line_wrap();
        int ready_low;
        ready_low = 0;
        do_reset();
        for (int i = 0; i < COLS; i++) begin
            send("B");
            if (char_ready !== 1'b1) ready_low++;
        end
        @(negedge clock);
        #1;
        checks++;
        if ({cur_row, cur_col} !== {3'd1, 5'd0} || ready_low != 0 || char_ready !== 1'b1) begin
            errors++;
            $display("FAIL line_wrap: row=%0d col=%0d ready_low_count=%0d required row=1 col=0 count=0",
                     cur_row, cur_col, ready_low);
        end
    endtask

    task automatic test_scroll();
        do_reset();
        for (int i = 0; i < ROWS * COLS - 1; i++) send(8'h61 + 8'(i % 26));
        send("C");
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            checks++;
            if (scroll_req !== exp_scroll || char_ready !== 1'b0 || {cur_row, cur_col} !== {3'd6, 5'd0}) begin
                errors++;
                $display("FAIL scroll_hold: scroll_req=%b ready=%b row=%0d col=%0d required 1 0 6 0",
                         scroll_req, char_ready, cur_row, cur_col);
            end
        end
        @(negedge clock);
        scroll_ack = 1'b1;
        @(negedge clock);
        scroll_ack = 1'b0;
        exp_scroll = 0;
        #1;
        checks++;
        if (scroll_req !== 1'b0 || char_ready !== 1'b1) begin
            errors++;
            $display("FAIL scroll_release: scroll_req=%b ready=%b required 0 1", scroll_req, char_ready);
        end
        send("D");
        // An acknowledge with no scroll outstanding must change nothing.
        @(negedge clock);
        scroll_ack = 1'b1;
        @(negedge clock);
        scroll_ack = 1'b0;
        #1;
        checks++;
        if (scroll_req !== 1'b0 || char_ready !== 1'b1 || {cur_row, cur_col} !== {3'd6, 5'd1} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL idle_ack: scroll_req=%b ready=%b row=%0d col=%0d pending=%0d required 0 1 6 1 0",
                     scroll_req, char_ready, cur_row, cur_col, exp_q.size());
        end
    endtask

    task automatic test_clear();
        int c0;
        do_reset();
        repeat (3) send(8'h0A);
        repeat (7) send("x");
        @(negedge clock);
        #1;
        checks++;
        if ({cur_row, cur_col} !== {3'd3, 5'd7}) begin
            errors++;
            $display("FAIL clear_setup: row=%0d col=%0d required row=3 col=7", cur_row, cur_col);
        end
        c0 = clear_cnt;
        send(8'hFF);
        @(negedge clock);
        #1;
        checks++;
        if (clear_req !== 1'b1 || glyph_we !== 1'b0 || {cur_row, cur_col} !== {3'd0, 5'd0}) begin
            errors++;
            $display("FAIL clear_pulse: clear_req=%b we=%b row=%0d col=%0d required 1 0 0 0",
                     clear_req, glyph_we, cur_row, cur_col);
        end
        repeat (3) @(negedge clock);
        #1;
        checks++;
        if (clear_req !== 1'b0 || clear_cnt != c0 + 1) begin
            errors++;
            $display("FAIL clear_width: clear_req=%b pulses=%0d required 0 and 1 pulse", clear_req, clear_cnt - c0);
        end
    endtask

    task automatic test_newline_map();
        logic [7:0] codes [10];
        codes = '{8'h7F, 8'hC3, 8'h30, 8'h39, 8'h5A, 8'h61, 8'h80, 8'h2F, 8'h7B, 8'h08};
        do_reset();
        repeat (2) send(8'h0A);
        repeat (5) send("q");
        send(8'h0A);
        @(negedge clock);
        #1;
        checks++;
        if ({cur_row, cur_col} !== {3'd3, 5'd0} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL newline: row=%0d col=%0d pending=%0d required row=3 col=0 pending=0",
                     cur_row, cur_col, exp_q.size());
        end
        for (int i = 0; i < 10; i++) begin
`ifdef TEXT_FEEDER_BACKSPACE_EN
            if (codes[i] != 8'h08) send(codes[i]);
`else
            send(codes[i]);
`endif
        end
        @(negedge clock);
        #1;
        checks++;
        if (exp_q.size() != 0 || {cur_row, cur_col} !== {3'(exp_row), 5'(exp_col)}) begin
            errors++;
            $display("FAIL mapping_drain: pending=%0d row=%0d col=%0d required 0 %0d %0d",
                     exp_q.size(), cur_row, cur_col, exp_row, exp_col);
        end
    endtask

`ifdef TEXT_FEEDER_BACKSPACE_EN
    task automatic test_backspace();
        do_reset();
        repeat (COLS) send("B");
        send(8'h08);
        @(negedge clock);
        #1;
        checks++;
        if ({cur_row, cur_col} !== {3'd0, 5'd19} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backspace_wrap: row=%0d col=%0d pending=%0d required row=0 col=19 pending=0",
                     cur_row, cur_col, exp_q.size());
        end
        do_reset();
        send(8'h08);
        @(negedge clock);
        #1;
        checks++;
        if ({cur_row, cur_col} !== {3'd0, 5'd0} || exp_q.size() != 0) begin
            errors++;
            $display("FAIL backspace_home: row=%0d col=%0d required row=0 col=0", cur_row, cur_col);
        end
    endtask
`endif

    task automatic test_reset_in_scroll();
        do_reset();
        for (int i = 0; i < ROWS * COLS; i++) send("M");
        @(negedge clock);
        #1;
        checks++;
        if (scroll_req !== 1'b1) begin
            errors++;
            $display("FAIL scroll_entry: scroll_req=%b required 1", scroll_req);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (scroll_req !== 1'b0 || char_ready !== 1'b1 || {cur_row, cur_col} !== {3'd0, 5'd0}) begin
            errors++;
            $display("FAIL reset_in_scroll: scroll_req=%b ready=%b row=%0d col=%0d required 0 1 0 0",
                     scroll_req, char_ready, cur_row, cur_col);
        end
        do_reset();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_line_wrap();
        test_scroll();
        test_clear();
        test_newline_map();
`ifdef TEXT_FEEDER_BACKSPACE_EN
        test_backspace();
`endif
        test_reset_in_scroll();
        repeat (2) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
